// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear sequencer: button conditioning, control FSM and tick prescaler.
// Optional build macro DEBOUNCE_EN adds a DB_CYCLES stability filter on each synchronized button.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       lap,
  input  logic       clear,
  input  logic       count_max,
  output logic       tick,
  output logic       count_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("stopwatch_ctrl: TICK_DIV must be at least 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("stopwatch_ctrl: DB_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic          r_count_clr;
  logic          w_count_clr_nxt;
  logic          r_disp_hold;
  logic          w_disp_hold_nxt;

  // Button bit order: [0] start, [1] lap, [2] clear
  logic [2:0] w_btn_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_cond;
  logic [2:0] r_prev;
  logic [2:0] w_pulse;

  assign w_btn_raw = {clear, lap, start};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] r_db_cnt [3];
  logic [2:0]     r_cond;

  // Conditioned level follows the synchronized level only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cond <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_cond[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_cond[i]   <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_cond = r_cond;
`else
  assign w_cond = r_sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev <= 3'b000;
    end else begin
      r_prev <= w_cond;
    end
  end

  assign w_pulse = w_cond & ~r_prev;

  // Priority: clear over start over lap; a lower event coinciding with a higher one is dropped
  logic w_ev_clr;
  logic w_ev_start;
  logic w_ev_lap;

  assign w_ev_clr   = w_pulse[2];
  assign w_ev_start = w_pulse[0] & ~w_pulse[2];
  assign w_ev_lap   = w_pulse[1] & ~w_pulse[0] & ~w_pulse[2];

  logic w_run;
  logic w_pre_last;
  logic w_term;

  assign w_run      = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_pre_last = (r_pre == PRE_MAX);
  assign w_term     = w_run & w_pre_last & count_max;

  always_comb begin
    w_state_nxt     = r_state;
    w_count_clr_nxt = 1'b0;
    w_pre_nxt       = r_pre;

    case (r_state)
      S_IDLE: begin
        if (w_ev_clr) begin
          w_count_clr_nxt = 1'b1;
        end else if (w_ev_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_ev_start || w_term) begin
          w_state_nxt = S_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = S_LAP;
        end
      end
      S_LAP: begin
        if (w_ev_start || w_term) begin
          w_state_nxt = S_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (w_ev_clr) begin
          w_state_nxt     = S_IDLE;
          w_count_clr_nxt = 1'b1;
        end else if (w_ev_start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Prescaler holds in PAUSE so a resume keeps the sub-tick fraction
    if (w_run) begin
      w_pre_nxt = w_pre_last ? '0 : r_pre + PW'(1);
    end else if ((r_state == S_PAUSE) && w_ev_clr) begin
      w_pre_nxt = '0;
    end

    w_disp_hold_nxt = (w_state_nxt == S_LAP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_count_clr <= 1'b0;
      r_disp_hold <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre       <= w_pre_nxt;
      r_count_clr <= w_count_clr_nxt;
      r_disp_hold <= w_disp_hold_nxt;
    end
  end

  assign tick      = w_run & w_pre_last & ~count_max;
  assign count_clr = r_count_clr;
  assign disp_hold = r_disp_hold;
  assign running   = w_run;
  assign state     = r_state;

endmodule
